// File: rtl/timer_controller_if.sv
// Control and status bundle for timer_controller.
// master drives the requests; slave is the timer.
interface timer_controller_if #(
  parameter int PW = 8
);
  logic          start_i;
  logic          stop_i;
  logic          hold_i;
  logic          periodic_i;
  logic [PW-1:0] period_i;
  logic          busy_o;
  logic          done_o;
  logic          tick_o;
  logic          err_o;
  logic [PW-1:0] count_o;

  modport master (
    output start_i, stop_i, hold_i,
    output periodic_i, period_i,
    input  busy_o, done_o, tick_o,
    input  err_o, count_o
  );

  modport slave (
    input  start_i, stop_i, hold_i,
    input  periodic_i, period_i,
    output busy_o, done_o, tick_o,
    output err_o, count_o
  );
endinterface

// File: rtl/timer_controller.sv
// Three-state period timer: one-shot or periodic,
// with hold, abort and out-of-range start rejection.
module timer_controller #(
  parameter int MAX_PERIOD = 255
) (
  input logic         clk_i,
  input logic         s_rst_n_i,
  timer_controller_if.slave bus
);
  localparam int PW = $clog2(MAX_PERIOD + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [PW-1:0] count_q;
  logic [PW-1:0] period_q;
  logic          periodic_q;
  logic          err_q;
  logic          start_ok;
  logic          at_term;

  assign start_ok =
    int'(bus.period_i) <= MAX_PERIOD;
  assign at_term = count_q == period_q;

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.stop_i) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (!bus.hold_i) begin
            if (!at_term)
              count_q <= count_q + PW'(1);
            else if (periodic_q)
              count_q <= '0;
            else
              state_q <= DONE;
          end
        end
        IDLE, DONE: begin
          // count is already zero in IDLE, so stop there is a no-op
          if (bus.stop_i) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (bus.start_i) begin
            if (start_ok) begin
              state_q    <= RUN;
              count_q    <= '0;
              period_q   <= bus.period_i;
              periodic_q <= bus.periodic_i;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy_o  = state_q == RUN;
  assign bus.done_o  = state_q == DONE;
  assign bus.tick_o  = (state_q == RUN) && at_term
                       && !bus.hold_i;
  assign bus.err_o   = err_q;
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_timer_controller.sv
// Directed-vector scoreboard bench for timer_controller.
// Stimulus pushes per-cycle expectations; a monitor checks them.
module tb_timer_controller;
  localparam int MAXP = 200;
  localparam int PW   = $clog2(MAXP + 1);

  logic clk_i = 1'b0;
  logic s_rst_n_i;

  timer_controller_if #(.PW(PW)) tif ();

  timer_controller #(.MAX_PERIOD(MAXP)) dut (
    .clk_i     (clk_i),
    .s_rst_n_i (s_rst_n_i),
    .bus       (tif.slave)
  );

  always #5 clk_i = ~clk_i;

  logic [PW+3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [PW+3:0] e;
      logic [PW+3:0] a;
      e = exp_q.pop_front();
      a = {tif.busy_o, tif.done_o, tif.tick_o,
           tif.err_o, tif.count_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d busy/done/tick/err/count got %b want %b",
                 checks, a, e);
      end
    end
  end

  task automatic c(
    input logic rst, st, sp, hd, per,
    input int   prd,
    input logic b, d, t, e,
    input int   cnt
  );
    @(posedge clk_i);
    #1;
    s_rst_n_i      = rst;
    tif.start_i    = st;
    tif.stop_i     = sp;
    tif.hold_i     = hd;
    tif.periodic_i = per;
    tif.period_i   = PW'(prd);
    exp_q.push_back({b, d, t, e, PW'(cnt)});
  endtask

  initial begin
    s_rst_n_i      = 1'b0;
    tif.start_i    = 1'b0;
    tif.stop_i     = 1'b0;
    tif.hold_i     = 1'b0;
    tif.periodic_i = 1'b0;
    tif.period_i   = '0;
    repeat (2) @(posedge clk_i);

    // periodic P=3, stop on a tick cycle
    c(1,1,0,0,1,3, 0,0,0,0,0);
    for (int i = 1; i <= 11; i++)
      c(1,0,0,0,1,3, 1,0,(i % 4 == 0),0,(i - 1) % 4);
    c(1,0,1,0,1,3, 1,0,1,0,3);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // one-shot P=2, re-arm P=1, reject in DONE
    c(1,1,0,0,0,2, 0,0,0,0,0);
    c(1,0,0,0,0,2, 1,0,0,0,0);
    c(1,0,0,0,0,2, 1,0,0,0,1);
    c(1,0,0,0,0,2, 1,0,1,0,2);
    c(1,0,0,0,0,2, 0,1,0,0,2);
    c(1,1,0,0,0,1, 0,1,0,0,2);
    c(1,0,0,0,0,1, 1,0,0,0,0);
    c(1,0,0,0,0,1, 1,0,1,0,1);
    c(1,0,0,0,0,1, 0,1,0,0,1);
    c(1,1,0,0,0,201, 0,1,0,0,1);
    c(1,0,0,0,0,0, 0,1,0,1,1);
    c(1,0,1,0,0,0, 0,1,0,0,1);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // out-of-range then max period one-shot
    c(1,1,0,0,0,201, 0,0,0,0,0);
    c(1,0,0,0,0,0, 0,0,0,1,0);
    c(1,0,0,0,0,0, 0,0,0,0,0);
    c(1,1,0,0,0,200, 0,0,0,0,0);
    for (int i = 0; i <= 200; i++)
      c(1,0,0,0,0,0, 1,0,(i == 200),0,i);
    c(1,0,0,0,0,0, 0,1,0,0,200);
    c(1,0,1,0,0,0, 0,1,0,0,200);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // periodic P=4 with hold mid-count and at terminal
    c(1,1,0,0,1,4, 0,0,0,0,0);
    c(1,0,0,0,1,4, 1,0,0,0,0);
    c(1,0,0,0,1,4, 1,0,0,0,1);
    c(1,0,0,1,1,4, 1,0,0,0,2);
    c(1,0,0,1,1,4, 1,0,0,0,2);
    c(1,0,0,1,1,4, 1,0,0,0,2);
    c(1,0,0,0,1,4, 1,0,0,0,2);
    c(1,0,0,0,1,4, 1,0,0,0,3);
    c(1,0,0,1,1,4, 1,0,0,0,4);
    c(1,0,0,1,1,4, 1,0,0,0,4);
    c(1,0,0,0,1,4, 1,0,1,0,4);
    c(1,0,0,0,1,4, 1,0,0,0,0);
    c(1,0,1,0,1,4, 1,0,0,0,1);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // start+stop together; start and new config ignored in RUN
    c(1,1,1,0,1,5, 0,0,0,0,0);
    c(1,0,0,0,1,5, 0,0,0,0,0);
    c(1,1,0,0,1,5, 0,0,0,0,0);
    c(1,0,0,0,1,5, 1,0,0,0,0);
    c(1,1,1,0,1,5, 1,0,0,0,1);
    c(1,0,0,0,0,0, 0,0,0,0,0);
    c(1,1,0,0,1,2, 0,0,0,0,0);
    c(1,1,0,0,0,7, 1,0,0,0,0);
    c(1,1,0,0,0,7, 1,0,0,0,1);
    c(1,0,0,0,0,7, 1,0,1,0,2);
    c(1,0,0,0,0,7, 1,0,0,0,0);
    c(1,0,1,0,0,7, 1,0,0,0,1);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // reset mid-run, no auto resume
    c(1,1,0,0,1,9, 0,0,0,0,0);
    for (int i = 0; i <= 4; i++)
      c(1,0,0,0,1,9, 1,0,0,0,i);
    c(0,0,0,0,1,9, 1,0,0,0,5);
    c(1,0,0,0,0,0, 0,0,0,0,0);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    // P=0 periodic then one-shot
    c(1,1,0,0,1,0, 0,0,0,0,0);
    c(1,0,0,0,1,0, 1,0,1,0,0);
    c(1,0,0,0,1,0, 1,0,1,0,0);
    c(1,0,1,0,1,0, 1,0,1,0,0);
    c(1,0,0,0,0,0, 0,0,0,0,0);
    c(1,1,0,0,0,0, 0,0,0,0,0);
    c(1,0,0,0,0,0, 1,0,1,0,0);
    c(1,0,0,0,0,0, 0,1,0,0,0);
    c(1,0,1,0,0,0, 0,1,0,0,0);
    c(1,0,0,0,0,0, 0,0,0,0,0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk_i);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
